memory_port_arbiter: RTL

Shares the single synchronous memory port between the CPU (instruction fetch, loads and stores) and the video/raycast fetch engine. Video requests normally win, because the display path is real-time. A starvation counter forces a CPU grant after a bounded run of video grants. The block sits between `cpu`, the video fetch unit and the memory block, and carries all memory address, write and read-return traffic.

---
 rtl/memory_arbiter_pkg.sv | 17 +
 rtl/memory_port_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory port arbiter and its clients.
//   MEM_ADDR_WIDTH / MEM_DATA_WIDTH : default memory bus widths used by the
//                                     cpu, the video fetch unit and the arbiter
//   owner_e                         : which requester owns the read return
//                                     arriving in the next cycle
package memory_arbiter_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 16;
  localparam int unsigned MEM_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_CPU   = 2'd1,
    OWNER_VIDEO = 2'd2
  } owner_e;

endpackage

// File: rtl/memory_port_arbiter.sv
// Shares the single synchronous memory port between the CPU and the video
// fetch engine. Video wins contention unless the CPU has been passed over
// STARVE_LIMIT times in a row. Grants are combinational (zero latency); read
// data returns one cycle later and is steered by a registered owner tag.
//
// Ports:
//   clock, reset            : clock, asynchronous active-low reset
//   cpu_request/_write_enable/_address/_write_data : CPU access request
//   cpu_grant               : CPU access is on the memory port this cycle
//   cpu_read_valid/_data    : CPU read return
//   video_request/_address  : video read request
//   video_grant             : video read is on the memory port this cycle
//   video_read_valid/_data  : video read return
//   memory_read_data        : memory output (1-cycle read latency)
//   memory_write_enable/_address/_write_data : memory port drive
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = MEM_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_request,
  input  logic                  cpu_write_enable,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic                  cpu_grant,
  output logic                  cpu_read_valid,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  input  logic                  video_request,
  input  logic [ADDR_WIDTH-1:0] video_address,
  output logic                  video_grant,
  output logic                  video_read_valid,
  output logic [DATA_WIDTH-1:0] video_read_data,
  input  logic [DATA_WIDTH-1:0] memory_read_data,
  output logic                  memory_write_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0] memory_write_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  owner_e     owner_q, owner_d;
  logic       cpu_win, video_win;
  logic       at_limit;

  assign at_limit = (starve_q == LIMIT);

  // Winner selection. Grants are gated by reset so that nothing reaches the
  // memory port while reset is held, whatever the request inputs do.
  always_comb begin
    cpu_win   = 1'b0;
    video_win = 1'b0;
    if (reset) begin
      if (cpu_request && (!video_request || at_limit)) begin
        cpu_win = 1'b1;
      end else if (video_request) begin
        video_win = 1'b1;
      end
    end
  end

  always_comb begin
    memory_write_enable = 1'b0;
    memory_address      = '0;
    memory_write_data   = '0;
    if (cpu_win) begin
      memory_write_enable = cpu_write_enable;
      memory_address      = cpu_address;
      memory_write_data   = cpu_write_data;
    end else if (video_win) begin
      memory_address      = video_address;
    end
  end

  assign cpu_grant   = cpu_win;
  assign video_grant = video_win;

  // Starvation counter and return-owner next state.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_request || cpu_win) begin
      starve_d = '0;
    end else if (video_win && !at_limit) begin
      starve_d = starve_q + 4'd1;
    end

    owner_d = OWNER_NONE;
    if (cpu_win && !cpu_write_enable) begin
      owner_d = OWNER_CPU;
    end else if (video_win) begin
      owner_d = OWNER_VIDEO;
    end
  end

  // Clearing owner on reset drops any read return still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      owner_q  <= OWNER_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  assign cpu_read_valid   = (owner_q == OWNER_CPU);
  assign video_read_valid = (owner_q == OWNER_VIDEO);
  assign cpu_read_data    = memory_read_data;
  assign video_read_data  = memory_read_data;

endmodule
